time_syn_calc: RTL and testbench

Slave-side time-synchronisation engine sitting directly downstream of `time_syn_rx`. It consumes the slot-start pulse and the decoded return/standard-time words from `time_syn_rx`. It issues timestamp requests toward the control-port transmitter, measures the round-trip delay, and corrects a free-running 64-bit local time counter. All other logic in the node uses that counter as its notion of network time.

---
 rtl/time_syn_calc.sv | 146 ++++++++++++++
 tb/tb_time_syn_calc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_syn_calc.sv
// Slave-side time synchronisation: request/response exchange with the master,
// round-trip delay measurement and correction of the free-running local time.
module time_syn_calc #(
    parameter logic [63:0] P_TICK    = 64'd8,
    parameter logic [31:0] P_TIMEOUT = 32'd100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_syn_start,
    input  logic [63:0] i_recv_std_time,
    input  logic        i_recv_std_valid,
    input  logic [63:0] i_recv_return_ts,
    input  logic        i_recv_return_valid,
    output logic        o_req_valid,
    output logic [63:0] o_req_ts,
    input  logic        i_req_ready,
    output logic [63:0] o_local_time,
    output logic [63:0] o_link_delay,
    output logic        o_syn_done,
    output logic        o_syn_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_REQ,
        S_WAIT_RESP,
        S_CALC,
        S_ADJUST
    } state_e;

    state_e      state_q;
    logic [63:0] local_time_q;
    logic [63:0] req_ts_q;
    logic [63:0] t2_q;
    logic [63:0] ts_std_q;
    logic [63:0] echo_q;
    logic [63:0] t3_q;
    logic [63:0] delay_q;
    logic [63:0] link_delay_q;
    logic [31:0] tmo_cnt_q;
    logic        std_flag_q;
    logic        ret_flag_q;
    logic        req_valid_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] tmo_cnt_d;
    logic        both_seen_d;
    logic [63:0] delay_d;
    logic [63:0] adj_time_d;

    always_comb begin
        tmo_cnt_d   = tmo_cnt_q + 32'd1;
        // A strobe arriving this cycle counts as already seen.
        both_seen_d = (std_flag_q | i_recv_std_valid) & (ret_flag_q | i_recv_return_valid);
        delay_d     = (t3_q - req_ts_q) >> 1;
        // Master time plus path delay plus time elapsed locally since t2 arrived.
        adj_time_d  = t2_q + delay_q + (local_time_q - ts_std_q) + P_TICK;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            local_time_q <= '0;
            req_ts_q     <= '0;
            t2_q         <= '0;
            ts_std_q     <= '0;
            echo_q       <= '0;
            t3_q         <= '0;
            delay_q      <= '0;
            link_delay_q <= '0;
            tmo_cnt_q    <= '0;
            std_flag_q   <= 1'b0;
            ret_flag_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            local_time_q <= local_time_q + P_TICK;
            case (state_q)
                S_IDLE: begin
                    if (i_syn_start) begin
                        req_ts_q    <= local_time_q;
                        std_flag_q  <= 1'b0;
                        ret_flag_q  <= 1'b0;
                        req_valid_q <= 1'b1;
                        state_q     <= S_SEND_REQ;
                    end
                end
                S_SEND_REQ: begin
                    if (req_valid_q && i_req_ready) begin
                        req_valid_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (i_recv_std_valid) begin
                        t2_q       <= i_recv_std_time;
                        ts_std_q   <= local_time_q;
                        std_flag_q <= 1'b1;
                    end
                    if (i_recv_return_valid) begin
                        echo_q     <= i_recv_return_ts;
                        t3_q       <= local_time_q;
                        ret_flag_q <= 1'b1;
                    end
                    if (both_seen_d) begin
                        state_q <= S_CALC;
                    end else if (tmo_cnt_d == P_TIMEOUT) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_CALC: begin
                    if (echo_q != req_ts_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        delay_q <= delay_d;
                        state_q <= S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    local_time_q <= adj_time_d;
                    link_delay_q <= delay_q;
                    done_q       <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_req_valid  = req_valid_q;
    assign o_req_ts     = req_ts_q;
    assign o_local_time = local_time_q;
    assign o_link_delay = link_delay_q;
    assign o_syn_done   = done_q;
    assign o_syn_err    = err_q;

endmodule

// File: tb/tb_time_syn_calc.sv
// Directed and randomized exchanges for time_syn_calc, checked against a
// cycle-counting model of local time and the delay/correction arithmetic.
module tb_time_syn_calc;

    localparam logic [63:0] TICK = 64'd1;
    localparam logic [31:0] TMO  = 32'd50;

    logic        clk = 1'b0;
    logic        rst;
    logic        syn_start;
    logic [63:0] std_time;
    logic        std_valid;
    logic [63:0] ret_ts;
    logic        ret_valid;
    logic        req_valid;
    logic [63:0] req_ts;
    logic        req_ready;
    logic [63:0] local_time;
    logic [63:0] link_delay;
    logic        syn_done;
    logic        syn_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [63:0] lt;
    logic [63:0] last_delay;

    time_syn_calc #(.P_TICK(TICK), .P_TIMEOUT(TMO)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_syn_start         (syn_start),
        .i_recv_std_time     (std_time),
        .i_recv_std_valid    (std_valid),
        .i_recv_return_ts    (ret_ts),
        .i_recv_return_valid (ret_valid),
        .o_req_valid         (req_valid),
        .o_req_ts            (req_ts),
        .i_req_ready         (req_ready),
        .o_local_time        (local_time),
        .o_link_delay        (link_delay),
        .o_syn_done          (syn_done),
        .o_syn_err           (syn_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Advance one cycle; local time in the model moves by one tick.
    task automatic step();
        @(posedge clk);
        #1;
        lt = lt + TICK;
        chk("done_err_exclusive", {63'd0, syn_done & syn_err}, 64'd0);
    endtask

    task automatic idle_inputs();
        syn_start = 1'b0;
        std_valid = 1'b0;
        ret_valid = 1'b0;
        std_time  = rnd64();
        ret_ts    = rnd64();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_local"}, local_time, 64'd0);
        chk({tag, "_delay"}, link_delay, 64'd0);
        chk({tag, "_req_ts"}, req_ts, 64'd0);
        chk({tag, "_req_valid"}, {63'd0, req_valid}, 64'd0);
        chk({tag, "_done"}, {63'd0, syn_done}, 64'd0);
        chk({tag, "_err"}, {63'd0, syn_err}, 64'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        req_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        lt = '0;
        last_delay = '0;
    endtask

    // One exchange starting this cycle. a/b: offsets (cycles into WAIT_RESP)
    // of the std and return strobes; bp: cycles of back-pressure.
    task automatic exchange(input logic [63:0] t2, input int unsigned a, input int unsigned b,
                            input bit bad_echo, input int unsigned bp);
        logic [63:0] t1, t3, ts_std, d, adj;
        int unsigned last;
        t1 = lt;
        t3 = '0;
        ts_std = '0;
        req_ready = (bp == 0);
        syn_start = 1'b1;
        step();
        syn_start = 1'b0;
        chk("req_valid", {63'd0, req_valid}, 64'd1);
        chk("req_ts", req_ts, t1);
        for (int unsigned i = 0; i < bp; i++) begin
            syn_start = 1'($urandom_range(0, 1));
            std_valid = 1'($urandom_range(0, 1));
            ret_valid = 1'($urandom_range(0, 1));
            std_time  = rnd64();
            ret_ts    = t1;
            step();
            chk("bp_req_valid", {63'd0, req_valid}, 64'd1);
            chk("bp_req_ts", req_ts, t1);
        end
        idle_inputs();
        req_ready = 1'b1;
        step();
        chk("req_dropped", {63'd0, req_valid}, 64'd0);
        last = (a > b) ? a : b;
        for (int unsigned c = 0; c <= last; c++) begin
            syn_start = 1'($urandom_range(0, 1));
            std_valid = (c == a) || (c == 0 && a > 0 && a <= b);
            std_time  = (c == a) ? t2 : rnd64();
            ret_valid = (c == b);
            ret_ts    = (c == b) ? (bad_echo ? t1 + 64'd1 : t1) : rnd64();
            if (c == a) ts_std = lt;
            if (c == b) t3 = lt;
            step();
        end
        idle_inputs();
        chk("calc_no_done", {63'd0, syn_done}, 64'd0);
        chk("calc_no_err", {63'd0, syn_err}, 64'd0);
        d = (t3 - t1) >> 1;
        step();
        if (bad_echo) begin
            chk("mismatch_err", {63'd0, syn_err}, 64'd1);
            chk("mismatch_no_done", {63'd0, syn_done}, 64'd0);
            chk("mismatch_local", local_time, lt);
            chk("mismatch_delay", link_delay, last_delay);
            step();
            chk("mismatch_err_clear", {63'd0, syn_err}, 64'd0);
            chk("mismatch_local_next", local_time, lt);
        end else begin
            adj = t2 + d + (lt - ts_std) + TICK;
            step();
            lt = adj;
            last_delay = d;
            chk("done_pulse", {63'd0, syn_done}, 64'd1);
            chk("done_local", local_time, adj);
            chk("done_delay", link_delay, d);
            step();
            chk("done_clear", {63'd0, syn_done}, 64'd0);
            chk("post_local", local_time, lt);
        end
        chk("post_req_valid", {63'd0, req_valid}, 64'd0);
        chk("post_req_ts", req_ts, t1);
    endtask

    initial begin
        do_reset();
        chk("reset_local_after_release", local_time, lt);

        // Nominal: t1 = 21, both strobes at local time 61, master time 1000.
        repeat (21) step();
        chk("count_from_reset", local_time, 64'd21);
        exchange(64'd1000, 38, 38, 1'b0, 0);
        chk("nominal_delay", link_delay, 64'd20);
        chk("nominal_local_plus1", local_time, 64'd1024);

        // Response orderings: std first, return first, simultaneous.
        exchange(rnd64(), 2, 7, 1'b0, 0);
        exchange(rnd64(), 7, 2, 1'b0, 0);
        exchange(rnd64(), 4, 4, 1'b0, 0);

        // Timeout with no responses, then an immediate new start.
        syn_start = 1'b1;
        req_ready = 1'b1;
        step();
        syn_start = 1'b0;
        step();
        repeat (49) step();
        chk("timeout_not_yet", {63'd0, syn_err}, 64'd0);
        step();
        chk("timeout_err", {63'd0, syn_err}, 64'd1);
        chk("timeout_local", local_time, lt);
        chk("timeout_delay", link_delay, last_delay);
        exchange(rnd64(), 3, 5, 1'b0, 0);

        // Echo mismatch, then back-pressure with spurious starts.
        exchange(rnd64(), 3, 4, 1'b1, 0);
        exchange(rnd64(), 2, 6, 1'b0, 10);

        // Randomized exchanges.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) step();
            exchange(rnd64(), $urandom_range(0, 20), $urandom_range(0, 20),
                     1'b0, $urandom_range(0, 3));
        end

        // Wrap: bring local time to 2^64-5 and run an exchange across zero.
        exchange(64'hFFFF_FFFF_FFFF_FF80, 3, 3, 1'b0, 0);
        for (int i = 0; i < 300 && lt != 64'hFFFF_FFFF_FFFF_FFFB; i++) step();
        chk("wrap_setup", local_time, 64'hFFFF_FFFF_FFFF_FFFB);
        exchange(rnd64(), 6, 8, 1'b0, 0);
        chk("wrap_delay", link_delay, 64'd5);

        // Reset asserted in WAIT_RESP after a std strobe.
        syn_start = 1'b1;
        step();
        syn_start = 1'b0;
        step();
        std_valid = 1'b1;
        std_time  = rnd64();
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("midreset_hold");
        end
        rst = 1'b0;
        lt = '0;
        last_delay = '0;
        ret_valid = 1'b1;
        ret_ts = 64'd0;
        std_valid = 1'b1;
        step();
        idle_inputs();
        step();
        chk("stray_strobes_ignored", {63'd0, syn_done | syn_err | req_valid}, 64'd0);
        chk("recover_local", local_time, lt);
        exchange(rnd64(), 1, 9, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
